// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter for the single SDRAM controller command port.
// One transaction in flight, a one-cycle command drop between transactions, and a response timeout.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0][1:0]             req_cmd,
  input  logic [1:0][ADDR_W-1:0]      req_addr,
  input  logic [1:0][DATA_W-1:0]      req_wdata,
  output logic [1:0]                  req_ack,
  output logic [1:0][DATA_W-1:0]      req_rdata,
  output logic [1:0]                  req_err,
  output logic [1:0]                  command,
  output logic [ADDR_W-1:0]           data_address,
  output logic [DATA_W-1:0]           data_write,
  input  logic [DATA_W-1:0]           data_read,
  input  logic                        data_read_valid,
  input  logic                        data_write_done
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] CMD_IDLE = 2'd0, CMD_WR = 2'd1, CMD_RD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REL} state_t;

  state_t                    state_q;
  logic [1:0]                cmd_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [1:0]                ack_q, err_q;
  logic [1:0][DATA_W-1:0]    rdata_q;
  logic                      last_q;   // also the owner of the in-flight transaction
  logic [TW-1:0]             timer_q;

  logic [1:0] pend;
  logic       gnt_d;
  logic       done;

  always_comb begin
    pend[0] = (req_cmd[0] == CMD_WR) || (req_cmd[0] == CMD_RD);
    pend[1] = (req_cmd[1] == CMD_WR) || (req_cmd[1] == CMD_RD);
    // On a tie the client that did not win last time gets the port.
    gnt_d   = (pend[0] && pend[1]) ? ~last_q : pend[1];
    done    = ((cmd_q == CMD_WR) && data_write_done) ||
              ((cmd_q == CMD_RD) && data_read_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|pend) begin
            cmd_q   <= req_cmd[gnt_d];
            addr_q  <= req_addr[gnt_d];
            wdata_q <= req_wdata[gnt_d];
            last_q  <= gnt_d;
            timer_q <= '0;
            state_q <= S_WAIT;
          end else begin
            cmd_q <= CMD_IDLE;
          end
        end
        S_WAIT: begin
          // Completion is checked first so a strobe on the timeout cycle still acks.
          if (done) begin
            ack_q[last_q] <= 1'b1;
            if (cmd_q == CMD_RD) rdata_q[last_q] <= data_read;
            cmd_q   <= CMD_IDLE;
            state_q <= S_REL;
          end else if (timer_q == TLAST) begin
            err_q[last_q] <= 1'b1;
            cmd_q   <= CMD_IDLE;
            state_q <= S_REL;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_REL: begin
          timer_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack      = ack_q;
  assign req_err      = err_q;
  assign req_rdata    = rdata_q;
  assign command      = cmd_q;
  assign data_address = addr_q;
  assign data_write   = wdata_q;

endmodule
